// File: rtl/sdc_pkg.sv
// Shared constants and types for the SDRAM host master.
// U_ADDR_MSB / U_DATA_MSB normally come from define.v; fallbacks apply when it is absent.
`ifndef U_ADDR_MSB
`define U_ADDR_MSB 23
`endif
`ifndef U_DATA_MSB
`define U_DATA_MSB 31
`endif

package sdc_pkg;

  localparam int ADDR_W     = `U_ADDR_MSB + 1;
  localparam int DATA_W     = `U_DATA_MSB + 1;
  localparam int BE_W       = 4;
  localparam int FIFO_W     = DATA_W + BE_W;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int FIFO_CW    = 3;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  typedef struct packed {
    logic [BE_W-1:0]   be_n;
    logic [DATA_W-1:0] data;
  } wbeat_t;

endpackage

// File: rtl/sdc_hm_fifo.sv
// Four-entry write-beat FIFO with a combinational head.
// Push+pop at full replaces the head slot; push+pop at empty passes the input straight through.
module sdc_hm_fifo
  import sdc_pkg::*;
#(
  parameter int WIDTH = FIFO_W
) (
  input  logic               mclk,
  input  logic               s_resetn,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_din,
  output logic [WIDTH-1:0]   o_dout,
  output logic [FIFO_CW-1:0] o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_CW-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == FIFO_CW'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & (~o_empty | i_push);
  assign o_dout    = o_empty ? i_din : r_mem[r_rptr];

  always_ff @(posedge mclk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge mclk) begin
    if (!s_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/sdc_host_master.sv
// Host-side command sequencer in front of an SDRAM controller. Optional macro:
// SDC_HM_TIMEOUT_EN adds a request-ack watchdog that forces the error state.
//
// state | meaning
// INIT  | waiting for SDRAM initialisation
// IDLE  | ready for a command
// REQ   | request presented, waiting for ack
// WDATA | feeding write beats from the FIFO
// RDATA | forwarding read beats
// ERR   | protocol violation, held until reset
module sdc_host_master
  import sdc_pkg::*;
(
  input  logic              mclk,
  input  logic              s_resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr_n,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [1:0]        cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  input  logic [BE_W-1:0]   wd_be_n,
  output logic              rd_out_valid,
  output logic [DATA_W-1:0] rd_out_data,
  output logic              rd_out_last,
  output logic              sdr_req,
  output logic [ADDR_W-1:0] sdr_req_adr,
  output logic [1:0]        sdr_req_len,
  output logic              sdr_req_wr_n,
  output logic [DATA_W-1:0] sdr_wr_data,
  output logic [BE_W-1:0]   sdr_wr_en_n,
  input  logic              sdr_req_ack,
  input  logic              sdr_wr_next,
  input  logic              sdr_rd_valid,
  input  logic [DATA_W-1:0] sdr_rd_data,
  input  logic              sdr_init_done,
  output logic              err
);

  logic [2:0]        r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_adr;
  logic [1:0]        r_len;
  logic              r_wr_n;
  logic [1:0]        r_beat;
  logic              r_err;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_rd_data;
`ifdef SDC_HM_TIMEOUT_EN
  logic [7:0]        r_tmo;
`endif

  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FIFO_CW-1:0] w_fifo_cnt;
  logic [FIFO_CW-1:0] w_need;
  logic              w_accept;
  logic              w_err_evt;
  wbeat_t            w_head;
  wbeat_t            w_din;

  assign wd_ready  = ~w_fifo_full;
  assign w_push    = wd_valid & wd_ready;
  assign w_pop     = (r_state == ST_WDATA) & sdr_wr_next & ~w_fifo_empty;
  assign w_din     = '{be_n: wd_be_n, data: wd_data};

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_need    = {1'b0, cmd_len} + 3'd1;
  assign w_accept  = cmd_valid & cmd_ready & (cmd_wr_n | (w_fifo_cnt >= w_need));

  // A write-next with nothing buffered is as fatal as one arriving in the wrong state.
  assign w_err_evt = (sdr_wr_next & ((r_state != ST_WDATA) | w_fifo_empty))
                   | (sdr_rd_valid & (r_state != ST_RDATA));

  sdc_hm_fifo #(.WIDTH(FIFO_W)) u_fifo (
    .mclk     (mclk),
    .s_resetn (s_resetn),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_din    (w_din),
    .o_dout   (w_head),
    .o_count  (w_fifo_cnt),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  always_ff @(posedge mclk) begin
    if (!s_resetn) begin
      r_state    <= ST_INIT;
      r_req      <= 1'b0;
      r_adr      <= '0;
      r_len      <= '0;
      r_wr_n     <= 1'b1;
      r_beat     <= '0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
`ifdef SDC_HM_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      if (w_err_evt) begin
        r_err   <= 1'b1;
        r_req   <= 1'b0;
        r_state <= ST_ERR;
      end else begin
        case (r_state)
          ST_INIT: if (sdr_init_done) r_state <= ST_IDLE;
          ST_IDLE: begin
            if (w_accept) begin
              r_adr   <= cmd_adr;
              r_len   <= cmd_len;
              r_wr_n  <= cmd_wr_n;
              r_req   <= 1'b1;
              r_state <= ST_REQ;
`ifdef SDC_HM_TIMEOUT_EN
              r_tmo   <= TIMEOUT_LIMIT;
`endif
            end
          end
          ST_REQ: begin
            if (sdr_req_ack) begin
              r_req   <= 1'b0;
              r_beat  <= '0;
              r_state <= r_wr_n ? ST_RDATA : ST_WDATA;
            end
`ifdef SDC_HM_TIMEOUT_EN
            else if (r_tmo == 8'd1) begin
              r_req   <= 1'b0;
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end else begin
              r_tmo <= r_tmo - 1'b1;
            end
`endif
          end
          ST_WDATA: begin
            if (sdr_wr_next) begin
              r_beat <= r_beat + 1'b1;
              if (r_beat == r_len) r_state <= ST_IDLE;
            end
          end
          ST_RDATA: begin
            if (sdr_rd_valid) begin
              r_rd_valid <= 1'b1;
              r_rd_last  <= (r_beat == r_len);
              r_beat     <= r_beat + 1'b1;
              if (r_beat == r_len) r_state <= ST_IDLE;
            end
          end
          ST_ERR:  r_req <= 1'b0;
          default: r_state <= ST_ERR;
        endcase
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!s_resetn)         r_rd_data <= '0;
    else if (sdr_rd_valid) r_rd_data <= sdr_rd_data;
  end

  assign sdr_req      = r_req;
  assign sdr_req_adr  = r_adr;
  assign sdr_req_len  = r_len;
  assign sdr_req_wr_n = r_wr_n;
  assign sdr_wr_data  = w_head.data;
  assign sdr_wr_en_n  = w_head.be_n;
  assign rd_out_valid = r_rd_valid;
  assign rd_out_data  = r_rd_data;
  assign rd_out_last  = r_rd_last;
  assign err          = r_err;

endmodule

// File: tb/tb_sdc_host_master.sv
// Scoreboard bench for sdc_host_master: write beats and read beats are queued
// as they are driven and compared as the DUT presents them.
module tb_sdc_host_master;
  import sdc_pkg::*;

  logic              mclk = 1'b0;
  logic              s_resetn;
  logic              cmd_valid, cmd_ready, cmd_wr_n;
  logic [ADDR_W-1:0] cmd_adr;
  logic [1:0]        cmd_len;
  logic              wd_valid, wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [BE_W-1:0]   wd_be_n;
  logic              rd_out_valid, rd_out_last;
  logic [DATA_W-1:0] rd_out_data;
  logic              sdr_req, sdr_req_wr_n;
  logic [ADDR_W-1:0] sdr_req_adr;
  logic [1:0]        sdr_req_len;
  logic [DATA_W-1:0] sdr_wr_data;
  logic [BE_W-1:0]   sdr_wr_en_n;
  logic              sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;
  logic [DATA_W-1:0] sdr_rd_data;
  logic              err;

  logic [FIFO_W-1:0] exp_wq[$];
  logic [DATA_W:0]   exp_rq[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 mclk = ~mclk;

  sdc_host_master dut (
    .mclk(mclk), .s_resetn(s_resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_n(cmd_wr_n),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_be_n(wd_be_n),
    .rd_out_valid(rd_out_valid), .rd_out_data(rd_out_data), .rd_out_last(rd_out_last),
    .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
    .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
    .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done), .err(err)
  );

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    n_total++;
    if (wd_ready !== 1'b1) $display("FAIL push_ready: wd_ready=%b want 1", wd_ready);
    else n_pass++;
    wd_valid = 1'b1; wd_data = d; wd_be_n = be;
    exp_wq.push_back({be, d});
    tick();
    wd_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic wr_n, input logic [ADDR_W-1:0] a, input logic [1:0] l);
    cmd_valid = 1'b1; cmd_wr_n = wr_n; cmd_adr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if (sdr_req !== 1'b1 || sdr_req_adr !== a || sdr_req_len !== l || sdr_req_wr_n !== wr_n)
      $display("FAIL req_fields: req=%b adr=%h len=%0d wr_n=%b want 1 %h %0d %b",
               sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, a, l, wr_n);
    else n_pass++;
  endtask

  task automatic pop_beats(input int n);
    logic [FIFO_W-1:0] e;
    for (int i = 0; i < n; i++) begin
      sdr_wr_next = 1'b1;
      e = exp_wq.pop_front();
      n_total++;
      if ({sdr_wr_en_n, sdr_wr_data} !== e)
        $display("FAIL wr_beat%0d: got be_n=%h data=%h want %h", i, sdr_wr_en_n, sdr_wr_data, e);
      else n_pass++;
      tick();
    end
    sdr_wr_next = 1'b0;
  endtask

  task automatic do_reset();
    s_resetn = 1'b0; sdr_init_done = 1'b0;
    cmd_valid = 0; cmd_wr_n = 1; cmd_adr = '0; cmd_len = '0;
    wd_valid = 0; wd_data = '0; wd_be_n = '0;
    sdr_req_ack = 0; sdr_wr_next = 0; sdr_rd_valid = 0; sdr_rd_data = '0;
    exp_wq.delete(); exp_rq.delete();
    tick(); tick();
    s_resetn = 1'b1;
  endtask

  task automatic bring_up();
    for (int i = 0; i < 8; i++) tick();
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL init_hold: cmd_ready=%b want 0", cmd_ready);
    else n_pass++;
    sdr_init_done = 1'b1;
    tick();
    n_total++;
    if (cmd_ready !== 1'b1 || err !== 1'b0)
      $display("FAIL init_done: cmd_ready=%b err=%b want 1 0", cmd_ready, err);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (cmd_ready !== 0 || sdr_req !== 0 || sdr_req_adr !== '0 || sdr_req_len !== 0 ||
        sdr_req_wr_n !== 1 || rd_out_valid !== 0 || rd_out_last !== 0 || err !== 0 || wd_ready !== 1)
      $display("FAIL reset_state: rdy=%b req=%b adr=%h len=%0d wr_n=%b rv=%b rl=%b err=%b wdr=%b",
               cmd_ready, sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n,
               rd_out_valid, rd_out_last, err, wd_ready);
    else n_pass++;
    bring_up();
  endtask

  task automatic test_write();
    push_beat(32'h11111111, 4'h0);
    push_beat(32'h22222222, 4'h1);
    push_beat(32'h33333333, 4'h2);
    push_beat(32'h44444444, 4'h3);
    n_total++;
    if (wd_ready !== 1'b0) $display("FAIL fifo_full: wd_ready=%b want 0", wd_ready);
    else n_pass++;
    issue_cmd(1'b0, 24'h000100, 2'd3);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (sdr_req !== 1'b1 || sdr_req_adr !== 24'h000100)
        $display("FAIL req_hold%0d: req=%b adr=%h want 1 000100", i, sdr_req, sdr_req_adr);
      else n_pass++;
    end
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    n_total++;
    if (sdr_req !== 1'b0) $display("FAIL req_drop: req=%b want 0", sdr_req);
    else n_pass++;
    pop_beats(4);
    n_total++;
    if (cmd_ready !== 1'b1 || wd_ready !== 1'b1 || err !== 1'b0 || exp_wq.size() != 0)
      $display("FAIL write_end: rdy=%b wdr=%b err=%b q=%0d want 1 1 0 0",
               cmd_ready, wd_ready, err, exp_wq.size());
    else n_pass++;
  endtask

  task automatic read_beat(input logic [DATA_W-1:0] d, input logic last);
    logic [DATA_W:0] e;
    sdr_rd_valid = 1'b1; sdr_rd_data = d;
    exp_rq.push_back({last, d});
    tick();
    sdr_rd_valid = 1'b0; sdr_rd_data = '0;
    n_total++;
    if (rd_out_valid !== 1'b1) begin
      $display("FAIL rd_valid: rd_out_valid=%b want 1", rd_out_valid);
    end else begin
      e = exp_rq.pop_front();
      if ({rd_out_last, rd_out_data} !== e)
        $display("FAIL rd_beat: last=%b data=%h want %h", rd_out_last, rd_out_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_read();
    issue_cmd(1'b1, 24'h000200, 2'd1);
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    read_beat(32'hA5A5A5A5, 1'b0);
    tick();
    n_total++;
    if (rd_out_valid !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL rd_gap: rd_out_valid=%b cmd_ready=%b want 0 0", rd_out_valid, cmd_ready);
    else n_pass++;
    read_beat(32'h5A5A5A5A, 1'b1);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL rd_idle: cmd_ready=%b want 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue_cmd(1'b1, 24'h000333, 2'd0);
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    read_beat(32'hCAFEF00D, 1'b1);
    push_beat(32'hDEADBEEF, 4'hE);
    issue_cmd(1'b0, 24'h000044, 2'd0);
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    pop_beats(1);
    n_total++;
    if (cmd_ready !== 1'b1 || err !== 1'b0)
      $display("FAIL b2b_end: cmd_ready=%b err=%b want 1 0", cmd_ready, err);
    else n_pass++;
  endtask

  task automatic test_len_gate();
    bit got;
    push_beat(32'h0000AAAA, 4'h0);
    push_beat(32'h0000BBBB, 4'h5);
    cmd_valid = 1'b1; cmd_wr_n = 1'b0; cmd_adr = 24'h000300; cmd_len = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (cmd_ready !== 1'b1 || sdr_req !== 1'b0)
        $display("FAIL len_gate%0d: cmd_ready=%b req=%b want 1 0", i, cmd_ready, sdr_req);
      else n_pass++;
    end
    push_beat(32'h0000CCCC, 4'hA);
    n_total++;
    if (sdr_req !== 1'b0) $display("FAIL len_gate3: req=%b want 0", sdr_req);
    else n_pass++;
    push_beat(32'h0000DDDD, 4'hF);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (sdr_req === 1'b1) got = 1'b1;
    end
    cmd_valid = 1'b0;
    n_total++;
    if (!got || sdr_req_len !== 2'd3) $display("FAIL len_accept: req=%b len=%0d want 1 3", sdr_req, sdr_req_len);
    else n_pass++;
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    pop_beats(4);
  endtask

  task automatic test_err();
    sdr_wr_next = 1'b1;
    tick();
    sdr_wr_next = 1'b0;
    n_total++;
    if (err !== 1'b1 || cmd_ready !== 1'b0 || sdr_req !== 1'b0)
      $display("FAIL err_set: err=%b cmd_ready=%b req=%b want 1 0 0", err, cmd_ready, sdr_req);
    else n_pass++;
    cmd_valid = 1'b1; cmd_wr_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cmd_valid = 1'b0;
    n_total++;
    if (sdr_req !== 1'b0 || err !== 1'b1) $display("FAIL err_hold: req=%b err=%b want 0 1", sdr_req, err);
    else n_pass++;
    for (int i = 0; i < 4; i++) push_beat(32'h1000 + i, 4'h0);
    n_total++;
    if (wd_ready !== 1'b0) $display("FAIL err_push: wd_ready=%b want 0", wd_ready);
    else n_pass++;
    exp_wq.delete();
    do_reset();
    n_total++;
    if (err !== 1'b0 || wd_ready !== 1'b1) $display("FAIL err_reset: err=%b wd_ready=%b want 0 1", err, wd_ready);
    else n_pass++;
    bring_up();
  endtask

  task automatic test_rd_outside();
    sdr_rd_valid = 1'b1;
    tick();
    sdr_rd_valid = 1'b0;
    n_total++;
    if (err !== 1'b1 || rd_out_valid !== 1'b0)
      $display("FAIL rd_outside: err=%b rd_out_valid=%b want 1 0", err, rd_out_valid);
    else n_pass++;
    do_reset();
    bring_up();
  endtask

`ifdef SDC_HM_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    issue_cmd(1'b1, 24'h000200, 2'd0);
    hi = 1;
    for (int i = 0; i < 300 && sdr_req === 1'b1; i++) begin
      tick();
      if (sdr_req === 1'b1) hi++;
    end
    n_total++;
    if (hi != 255 || err !== 1'b1) $display("FAIL timeout: req_cycles=%0d err=%b want 255 1", hi, err);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_len_gate();
    test_rd_outside();
`ifdef SDC_HM_TIMEOUT_EN
    test_timeout();
    do_reset();
    bring_up();
`endif
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
